// File: rtl/team_06_pkg.sv
// Shared types and helpers for the echo stage.
// Audio is offset-binary, AUDIO_MID is silence.
package team_06_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        READ,
        MIX,
        WRITE
    } echo_state_t;

    localparam int AUDIO_W = 8;
    localparam logic [AUDIO_W-1:0] AUDIO_MID = 8'd128;

    // dry + tap*gain/8 (floored), saturated back to offset-binary
    function automatic logic [AUDIO_W-1:0] mix_sample(
        input logic [AUDIO_W-1:0] dry,
        input logic [AUDIO_W-1:0] tap,
        input logic [2:0]         gain
    );
        logic signed [11:0] d;
        logic signed [11:0] w;
        logic signed [11:0] p;
        logic signed [11:0] m;
        d = $signed({4'b0, dry}) - 12'sd128;
        w = $signed({4'b0, tap}) - 12'sd128;
        p = w * $signed({9'b0, gain});
        m = d + (p >>> 3);
        if (m > 12'sd127) begin
            return 8'hFF;
        end else if (m < -12'sd128) begin
            return 8'h00;
        end else begin
            return m[7:0] ^ 8'h80;
        end
    endfunction

endpackage

// File: rtl/team_06_echo_if.sv
// Sample stream and control bundle for the echo stage.
// master drives samples/controls, slave returns the result.
interface team_06_echo_if #(
    parameter int AW = 6
);
    logic          sample_valid;
    logic [7:0]    audio_in;
    logic          en;
    logic [AW-1:0] delay_sel;
    logic [2:0]    decay;
    logic [7:0]    audio_out;
    logic          out_valid;
    logic          busy;

    modport master (
        output sample_valid, audio_in, en, delay_sel, decay,
        input  audio_out, out_valid, busy
    );

    modport slave (
        input  sample_valid, audio_in, en, delay_sel, decay,
        output audio_out, out_valid, busy
    );
endinterface

// File: rtl/team_06_delay_line.sv
// Circular sample store: one sync write, one registered read.
// Contents are not reset; the owner clears them explicitly.
module team_06_delay_line #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clkdiv,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clkdiv) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/team_06_echo.sv
// Feedback echo: mixes a decayed copy of an earlier output
// into each incoming sample, one sample per accepted strobe.
module team_06_echo
    import team_06_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clkdiv,
    input  logic           n_rst,
    team_06_echo_if.slave  bus
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    echo_state_t   state;
    echo_state_t   next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] delay_q;
    logic [AW-1:0] eff;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] waddr;
    logic [7:0]    dry;
    logic [7:0]    rd_data;
    logic [7:0]    wdata;
    logic [7:0]    res;
    logic [2:0]    decay_q;
    logic          en_q;
    logic          we;

    always_ff @(posedge clkdiv or negedge n_rst) begin
        if (!n_rst) begin
            state <= CLEAR;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            CLEAR:   if (clr_ptr == LAST) next = IDLE;
            IDLE:    if (bus.sample_valid) next = READ;
            READ:    next = MIX;
            MIX:     next = WRITE;
            WRITE:   next = IDLE;
            default: next = CLEAR;
        endcase
    end

    always_ff @(posedge clkdiv or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr        <= '0;
            clr_ptr       <= '0;
            delay_q       <= '0;
            decay_q       <= '0;
            en_q          <= 1'b0;
            dry           <= AUDIO_MID;
            bus.audio_out <= AUDIO_MID;
        end else begin
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            if (state == IDLE && bus.sample_valid) begin
                dry     <= bus.audio_in;
                delay_q <= bus.delay_sel;
                decay_q <= bus.decay;
                en_q    <= bus.en;
            end
            // audio_out doubles as the write-back register
            if (state == MIX) begin
                bus.audio_out <= res;
            end
            if (state == WRITE) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    assign eff     = (delay_q == '0) ? AW'(1) : delay_q;
    assign rd_addr = wr_ptr - eff;
    assign res     = en_q ? mix_sample(dry, rd_data, decay_q) : dry;

    assign we    = (state == CLEAR) || (state == WRITE);
    assign waddr = (state == CLEAR) ? clr_ptr : wr_ptr;
    assign wdata = (state == CLEAR) ? AUDIO_MID : bus.audio_out;

    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == WRITE);

    team_06_delay_line #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_line (
        .clkdiv (clkdiv),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr  (rd_addr),
        .rdata  (rd_data)
    );
endmodule
